// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard request / stage-control bundle between the 5-stage pipeline datapath and its
// stall/flush sequencer. The pipeline side is master; the sequencer is slave.
interface pipe_hazard_ctrl_if;
  logic        icache_miss;
  logic        dcache_miss;
  logic [4:0]  ifid_rs_addr;
  logic [4:0]  ifid_rt_addr;
  logic        idex_mem_r;
  logic [4:0]  idex_rd_addr;
  logic        ex_muldiv;
  logic        mem_redirect;
  logic        mem_syscall;
  logic        mem_eret;
  logic        mem_nop;

  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_stall;
  logic        idex_flush;
  logic        exmem_stall;
  logic        exmem_flush;
  logic        memwb_stall;
  logic        memwb_flush;
  logic [1:0]  pc_sel;
  logic        cp0_exc_w;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles;

  modport master (
    output icache_miss, dcache_miss, ifid_rs_addr, ifid_rt_addr, idex_mem_r,
           idex_rd_addr, ex_muldiv, mem_redirect, mem_syscall, mem_eret, mem_nop,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
           exmem_flush, memwb_stall, memwb_flush, pc_sel, cp0_exc_w, ctrl_state,
           stall_cycles
  );

  modport slave (
    input  icache_miss, dcache_miss, ifid_rs_addr, ifid_rt_addr, idex_mem_r,
           idex_rd_addr, ex_muldiv, mem_redirect, mem_syscall, mem_eret, mem_nop,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
           exmem_flush, memwb_stall, memwb_flush, pc_sel, cp0_exc_w, ctrl_state,
           stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: prioritises D-cache freeze,
// MEM-stage redirects, mul/div EX occupancy, load-use and I-cache bubbles.
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MISS = 2'd1,
    MDIV = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    EV_NONE,
    EV_DMISS,
    EV_SYSCALL,
    EV_ERET,
    EV_REDIR,
    EV_MDSTART,
    EV_LOADUSE,
    EV_IMISS,
    EV_MDHOLD,
    EV_MDBUSY,
    EV_MDLAST
  } event_t;

  localparam bit            MD_MULTI = (MD_LAT > 1);
  localparam logic [CW-1:0] MD_INIT  = CW'(MD_LAT - 1);

  state_t        state_r, state_nx;
  event_t        ev;
  logic [CW-1:0] md_cnt_r, md_cnt_nx;
  logic [31:0]   stall_cycles_r;
  logic          mem_valid;
  logic          load_use;

  function automatic logic is_load_use(input logic       mem_r,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt);
    return mem_r && (rd != 5'd0) && ((rd == rs) || (rd == rt));
  endfunction

  assign mem_valid = !hz.mem_nop;
  assign load_use  = is_load_use(hz.idex_mem_r, hz.idex_rd_addr,
                                 hz.ifid_rs_addr, hz.ifid_rt_addr);

  // Hazard decode: one winning event per cycle, shared by next-state and output logic.
  // MISS re-evaluates exactly like RUN so the pipeline resumes in the cycle dcache_miss drops.
  always_comb begin
    ev = EV_NONE;
    if (state_r == MDIV) begin
      if (hz.dcache_miss)              ev = EV_MDHOLD;
      else if (md_cnt_r > CW'(1))      ev = EV_MDBUSY;
      else                             ev = EV_MDLAST;
    end else begin
      if (hz.dcache_miss)                      ev = EV_DMISS;
      else if (mem_valid && hz.mem_syscall)    ev = EV_SYSCALL;
      else if (mem_valid && hz.mem_eret)       ev = EV_ERET;
      else if (mem_valid && hz.mem_redirect)   ev = EV_REDIR;
      else if (hz.ex_muldiv && MD_MULTI)       ev = EV_MDSTART;
      else if (load_use)                       ev = EV_LOADUSE;
      else if (hz.icache_miss)                 ev = EV_IMISS;
    end
  end

  // State register stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= RUN;
      md_cnt_r       <= '0;
      stall_cycles_r <= '0;
    end else begin
      state_r  <= state_nx;
      md_cnt_r <= md_cnt_nx;
      if (hz.pc_stall) stall_cycles_r <= stall_cycles_r + 32'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx  = state_r;
    md_cnt_nx = md_cnt_r;
    unique case (ev)
      EV_DMISS:   state_nx = MISS;
      EV_MDHOLD:  state_nx = MDIV;
      EV_MDSTART: begin
        state_nx  = MDIV;
        md_cnt_nx = MD_INIT;
      end
      EV_MDBUSY: begin
        state_nx  = MDIV;
        md_cnt_nx = md_cnt_r - CW'(1);
      end
      EV_MDLAST: begin
        state_nx  = RUN;
        md_cnt_nx = '0;
      end
      default:    state_nx = RUN;
    endcase
  end

  // Output logic; reset forces every control to its idle value without waiting for a clock.
  always_comb begin
    hz.pc_stall    = 1'b0;
    hz.ifid_stall  = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.idex_stall  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.exmem_stall = 1'b0;
    hz.exmem_flush = 1'b0;
    hz.memwb_stall = 1'b0;
    hz.memwb_flush = 1'b0;
    hz.pc_sel      = 2'd0;
    hz.cp0_exc_w   = 1'b0;
    if (reset) begin
      unique case (ev)
        EV_DMISS, EV_MDHOLD: begin
          hz.pc_stall    = 1'b1;
          hz.ifid_stall  = 1'b1;
          hz.idex_stall  = 1'b1;
          hz.exmem_stall = 1'b1;
          hz.memwb_stall = 1'b1;
        end
        EV_SYSCALL, EV_ERET, EV_REDIR: begin
          hz.ifid_flush  = 1'b1;
          hz.idex_flush  = 1'b1;
          hz.exmem_flush = 1'b1;
          hz.pc_sel      = (ev == EV_SYSCALL) ? 2'd2 :
                           (ev == EV_ERET)    ? 2'd3 : 2'd1;
          hz.cp0_exc_w   = (ev == EV_SYSCALL);
        end
        // EX keeps the mul/div; EX/MEM receives bubbles until the result is ready.
        EV_MDSTART, EV_MDBUSY: begin
          hz.pc_stall    = 1'b1;
          hz.ifid_stall  = 1'b1;
          hz.idex_stall  = 1'b1;
          hz.exmem_flush = 1'b1;
        end
        EV_LOADUSE: begin
          hz.pc_stall   = 1'b1;
          hz.ifid_stall = 1'b1;
          hz.idex_flush = 1'b1;
        end
        EV_IMISS: begin
          hz.pc_stall   = 1'b1;
          hz.ifid_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hz.ctrl_state   = state_r;
  assign hz.stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: the driver queues hand-computed
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic reset;

  pipe_hazard_ctrl_if if0 ();
  pipe_hazard_ctrl_if if1 ();

  pipe_hazard_ctrl #(.MD_LAT(4), .CW(4)) u_dut (.clk(clk), .reset(reset), .hz(if0.slave));
  pipe_hazard_ctrl #(.MD_LAT(1), .CW(4)) u_md1 (.clk(clk), .reset(reset), .hz(if1.slave));

  // The single-cycle mul/div instance only ever sees the mul/div request.
  assign if1.ex_muldiv    = if0.ex_muldiv;
  assign if1.icache_miss  = 1'b0;
  assign if1.dcache_miss  = 1'b0;
  assign if1.ifid_rs_addr = 5'd0;
  assign if1.ifid_rt_addr = 5'd0;
  assign if1.idex_mem_r   = 1'b0;
  assign if1.idex_rd_addr = 5'd0;
  assign if1.mem_redirect = 1'b0;
  assign if1.mem_syscall  = 1'b0;
  assign if1.mem_eret     = 1'b0;
  assign if1.mem_nop      = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_s, memwb_f}
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] ALLS = 9'b110101010;
  localparam logic [8:0] LU   = 9'b110010000;
  localparam logic [8:0] ICM  = 9'b101000000;
  localparam logic [8:0] FL3  = 9'b001010100;
  localparam logic [8:0] MD   = 9'b110100100;

  typedef struct packed {
    logic [8:0]  ctl;
    logic [1:0]  sel;
    logic        cp0;
    logic [1:0]  st;
    logic [31:0] sc;
  } exp_t;

  exp_t        sb_q[$];
  string       nm_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] sc_model = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic clr();
    if0.icache_miss  = 1'b0;
    if0.dcache_miss  = 1'b0;
    if0.ifid_rs_addr = 5'd0;
    if0.ifid_rt_addr = 5'd0;
    if0.idex_mem_r   = 1'b0;
    if0.idex_rd_addr = 5'd0;
    if0.ex_muldiv    = 1'b0;
    if0.mem_redirect = 1'b0;
    if0.mem_syscall  = 1'b0;
    if0.mem_eret     = 1'b0;
    if0.mem_nop      = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    if0.idex_mem_r   = 1'b1;
    if0.idex_rd_addr = rd;
    if0.ifid_rs_addr = rs;
    if0.ifid_rt_addr = rt;
  endtask

  // Queue the expectation for the inputs just driven, then move to the next cycle.
  task automatic issue(input logic [8:0] ctl, input logic [1:0] sel, input logic cp0,
                       input logic [1:0] st, input string nm);
    exp_t e;
    e.ctl = ctl; e.sel = sel; e.cp0 = cp0; e.st = st; e.sc = sc_model;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    if (ctl[8] && reset) sc_model = sc_model + 32'd1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = sb_q.pop_front();
      nm = nm_q.pop_front();
      chk({nm, ".ctl"}, {23'd0, if0.pc_stall, if0.ifid_stall, if0.ifid_flush, if0.idex_stall,
                         if0.idex_flush, if0.exmem_stall, if0.exmem_flush, if0.memwb_stall,
                         if0.memwb_flush}, {23'd0, e.ctl});
      chk({nm, ".pc_sel"},       {30'd0, if0.pc_sel},     {30'd0, e.sel});
      chk({nm, ".cp0_exc_w"},    {31'd0, if0.cp0_exc_w},  {31'd0, e.cp0});
      chk({nm, ".ctrl_state"},   {30'd0, if0.ctrl_state}, {30'd0, e.st});
      chk({nm, ".stall_cycles"}, if0.stall_cycles,        e.sc);
      chk({nm, ".md1_idle"},     {30'd0, if1.pc_stall, if1.ctrl_state == 2'd0}, 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    clr();
    @(posedge clk);
    #1;
    if0.dcache_miss = 1'b1;
    if0.ex_muldiv   = 1'b1;
    issue(NONE, 2'd0, 1'b0, 2'd0, "rst_hold");
    reset = 1'b1;
    clr();

    // Load-use detection
    set_lu(5'd5, 5'd5, 5'd0);  issue(LU,   2'd0, 1'b0, 2'd0, "lu_rs");
    set_lu(5'd5, 5'd3, 5'd5);  issue(LU,   2'd0, 1'b0, 2'd0, "lu_rt");
    set_lu(5'd0, 5'd0, 5'd0);  issue(NONE, 2'd0, 1'b0, 2'd0, "lu_r0");
    set_lu(5'd5, 5'd5, 5'd5); if0.idex_mem_r = 1'b0;
                               issue(NONE, 2'd0, 1'b0, 2'd0, "lu_noload");
    clr();

    // Mul/div occupancy: MD_LAT=4 holds EX for four cycles
    if0.ex_muldiv = 1'b1;
    issue(MD,   2'd0, 1'b0, 2'd0, "md_run");
    issue(MD,   2'd0, 1'b0, 2'd2, "md_c3");
    issue(MD,   2'd0, 1'b0, 2'd2, "md_c2");
    issue(NONE, 2'd0, 1'b0, 2'd2, "md_c1");
    clr();
    issue(NONE, 2'd0, 1'b0, 2'd0, "md_done");

    // D-cache freeze with a load-use pending behind it
    set_lu(5'd7, 5'd7, 5'd1);
    if0.dcache_miss = 1'b1;
    issue(ALLS, 2'd0, 1'b0, 2'd0, "dm1");
    issue(ALLS, 2'd0, 1'b0, 2'd1, "dm2");
    issue(ALLS, 2'd0, 1'b0, 2'd1, "dm3");
    issue(ALLS, 2'd0, 1'b0, 2'd1, "dm4");
    issue(ALLS, 2'd0, 1'b0, 2'd1, "dm5");
    if0.dcache_miss = 1'b0;
    issue(LU,   2'd0, 1'b0, 2'd1, "dm_lu");
    clr();
    issue(NONE, 2'd0, 1'b0, 2'd0, "dm_idle");
    if0.icache_miss = 1'b1;
    issue(ICM,  2'd0, 1'b0, 2'd0, "icm");

    // Redirect outranks load-use and I-cache miss; a bubble in MEM disqualifies it
    set_lu(5'd9, 5'd9, 5'd0);
    if0.mem_redirect = 1'b1;
    issue(FL3,  2'd1, 1'b0, 2'd0, "redir");
    if0.mem_nop = 1'b1;
    issue(LU,   2'd0, 1'b0, 2'd0, "redir_nop");
    clr();

    // Syscall / eret
    if0.mem_syscall = 1'b1;
    issue(FL3,  2'd2, 1'b1, 2'd0, "sys");
    clr();
    issue(NONE, 2'd0, 1'b0, 2'd0, "sys_after");
    if0.mem_eret = 1'b1;
    issue(FL3,  2'd3, 1'b0, 2'd0, "eret");
    if0.mem_syscall = 1'b1; if0.mem_redirect = 1'b1;
    issue(FL3,  2'd2, 1'b1, 2'd0, "sys_pri");
    if0.mem_nop = 1'b1;
    issue(NONE, 2'd0, 1'b0, 2'd0, "sys_nop");
    clr();

    // D-cache miss during MDIV holds the countdown
    if0.ex_muldiv = 1'b1;
    issue(MD,   2'd0, 1'b0, 2'd0, "mdd_run");
    if0.dcache_miss = 1'b1;
    issue(ALLS, 2'd0, 1'b0, 2'd2, "mdd_hold");
    if0.dcache_miss = 1'b0;
    issue(MD,   2'd0, 1'b0, 2'd2, "mdd_c3");
    issue(MD,   2'd0, 1'b0, 2'd2, "mdd_c2");
    issue(NONE, 2'd0, 1'b0, 2'd2, "mdd_c1");
    clr();
    issue(NONE, 2'd0, 1'b0, 2'd0, "mdd_done");

    // Asynchronous reset in the middle of MDIV (md_cnt=2)
    if0.ex_muldiv = 1'b1;
    issue(MD,   2'd0, 1'b0, 2'd0, "rmd_run");
    issue(MD,   2'd0, 1'b0, 2'd2, "rmd_c3");
    reset = 1'b0;
    sc_model = 32'd0;
    issue(NONE, 2'd0, 1'b0, 2'd0, "rmd_reset");
    reset = 1'b1;
    clr();
    issue(NONE, 2'd0, 1'b0, 2'd0, "rmd_post");
    if0.ex_muldiv = 1'b1;
    issue(MD,   2'd0, 1'b0, 2'd0, "rmd_restart");
    clr();

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
